// File: rtl/eth_header_parser_if.sv
// RX byte-stream bundle feeding the Ethernet header parser.
// The first byte on the wire travels in the MSB lane of rx_data.
interface eth_header_parser_if #(
  parameter int IN_BYTES = 1
);
  logic [8*IN_BYTES-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_sof;
  logic                  rx_abort;

  modport master (output rx_data, rx_valid, rx_sof, rx_abort);
  modport slave  (input  rx_data, rx_valid, rx_sof, rx_abort);
endinterface

// File: rtl/eth_header_parser.sv
// Ethernet header capture: places each RX byte into its fixed field slot by
// byte index, with optional absorption of one 802.1Q VLAN tag.
//
// state | meaning
// IDLE  | waiting for a start-of-frame beat
// HDR   | capturing header bytes 0-13
// VLAN  | capturing tag bytes 14-17 (TCI and inner EtherType)
// DONE  | header complete, fields held, following beats are payload
module eth_header_parser #(
  parameter int          IN_BYTES = 1,
  parameter bit          VLAN_EN  = 1'b1,
  parameter logic [15:0] TPID     = 16'h8100
) (
  input  logic                clk,
  input  logic                rst_n,
  eth_header_parser_if.slave  rx,
  output logic [47:0]         dst_mac,
  output logic [47:0]         src_mac,
  output logic [15:0]         eth_type,
  output logic [15:0]         vlan_tci,
  output logic                vlan_present,
  output logic [4:0]          hdr_len,
  output logic                hdr_valid,
  output logic                hdr_done,
  output logic                hdr_err,
  output logic                payload_valid
);

  generate
    if (IN_BYTES != 1 && IN_BYTES != 2) begin : g_bad_in_bytes
      $error("eth_header_parser: IN_BYTES must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, HDR, VLAN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  base_cnt, idx;
  logic [7:0]  lane;
  logic [47:0] dst_d, src_d;
  logic [15:0] type_d, tci_d;
  logic        vlan_d;
  logic [4:0]  len_d;
  logic        done_d, err_d;
  logic        in_hdr, new_frame, capture;

  assign hdr_valid     = (state_q == DONE);
  assign payload_valid = (state_q == DONE) & rx.rx_valid & ~rx.rx_sof;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dst_d     = dst_mac;
    src_d     = src_mac;
    type_d    = eth_type;
    tci_d     = vlan_tci;
    vlan_d    = vlan_present;
    len_d     = hdr_len;
    done_d    = 1'b0;
    err_d     = 1'b0;
    base_cnt  = cnt_q;
    idx       = '0;
    lane      = '0;
    capture   = 1'b0;
    in_hdr    = (state_q == HDR) || (state_q == VLAN);
    new_frame = rx.rx_valid & rx.rx_sof;

    if (rx.rx_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = in_hdr;
    end else begin
      // A start-of-frame beat restarts from a clean slate in every state.
      if (new_frame) begin
        capture  = 1'b1;
        base_cnt = '0;
        dst_d    = '0;
        src_d    = '0;
        type_d   = '0;
        tci_d    = '0;
        vlan_d   = 1'b0;
        len_d    = '0;
        err_d    = in_hdr;
        state_d  = HDR;
      end else if (rx.rx_valid && in_hdr) begin
        capture = 1'b1;
      end

      if (capture) begin
        for (int i = 0; i < IN_BYTES; i++) begin
          lane = rx.rx_data[8*(IN_BYTES-i)-1 -: 8];
          idx  = base_cnt + 5'(i);
          for (int k = 0; k < 6; k++)
            if (idx == 5'(k)) dst_d[8*(5-k) +: 8] = lane;
          for (int k = 6; k < 12; k++)
            if (idx == 5'(k)) src_d[8*(11-k) +: 8] = lane;
          for (int k = 12; k < 14; k++)
            if (idx == 5'(k)) type_d[8*(13-k) +: 8] = lane;
          for (int k = 14; k < 16; k++)
            if (idx == 5'(k)) tci_d[8*(15-k) +: 8] = lane;
          // inner EtherType replaces the TPID held in the same register
          for (int k = 16; k < 18; k++)
            if (idx == 5'(k)) type_d[8*(17-k) +: 8] = lane;
        end
        cnt_d = base_cnt + 5'(IN_BYTES);

        if (!new_frame) begin
          if (state_q == HDR && cnt_d == 5'd14) begin
            if (VLAN_EN && type_d == TPID) begin
              state_d = VLAN;
              vlan_d  = 1'b1;
            end else begin
              state_d = DONE;
              len_d   = 5'd14;
              done_d  = 1'b1;
            end
          end else if (state_q == VLAN && cnt_d == 5'd18) begin
            state_d = DONE;
            len_d   = 5'd18;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dst_mac      <= '0;
      src_mac      <= '0;
      eth_type     <= '0;
      vlan_tci     <= '0;
      vlan_present <= 1'b0;
      hdr_len      <= '0;
      hdr_done     <= 1'b0;
      hdr_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dst_mac      <= dst_d;
      src_mac      <= src_d;
      eth_type     <= type_d;
      vlan_tci     <= tci_d;
      vlan_present <= vlan_d;
      hdr_len      <= len_d;
      hdr_done     <= done_d;
      hdr_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_eth_header_parser.sv
// Directed bench: two 1-byte-lane parsers (VLAN on/off) share one stream,
// a 2-byte-lane parser gets its own stream.
module tb_eth_header_parser;
  localparam int V = 0;
  localparam int N = 1;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_header_parser_if #(.IN_BYTES(1)) bus1 ();
  eth_header_parser_if #(.IN_BYTES(2)) bus2 ();

  logic [47:0] dst [3];
  logic [47:0] src [3];
  logic [15:0] ety [3];
  logic [15:0] tci [3];
  logic [4:0]  len [3];
  logic        vp  [3];
  logic        hv  [3];
  logic        hd  [3];
  logic        he  [3];
  logic        pv  [3];

  eth_header_parser #(.IN_BYTES(1), .VLAN_EN(1'b1)) dut_v (
    .clk(clk), .rst_n(rst_n), .rx(bus1),
    .dst_mac(dst[V]), .src_mac(src[V]), .eth_type(ety[V]), .vlan_tci(tci[V]),
    .vlan_present(vp[V]), .hdr_len(len[V]), .hdr_valid(hv[V]), .hdr_done(hd[V]),
    .hdr_err(he[V]), .payload_valid(pv[V]));

  eth_header_parser #(.IN_BYTES(1), .VLAN_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rx(bus1),
    .dst_mac(dst[N]), .src_mac(src[N]), .eth_type(ety[N]), .vlan_tci(tci[N]),
    .vlan_present(vp[N]), .hdr_len(len[N]), .hdr_valid(hv[N]), .hdr_done(hd[N]),
    .hdr_err(he[N]), .payload_valid(pv[N]));

  eth_header_parser #(.IN_BYTES(2), .VLAN_EN(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .rx(bus2),
    .dst_mac(dst[W]), .src_mac(src[W]), .eth_type(ety[W]), .vlan_tci(tci[W]),
    .vlan_present(vp[W]), .hdr_len(len[W]), .hdr_valid(hv[W]), .hdr_done(hd[W]),
    .hdr_err(he[W]), .payload_valid(pv[W]));

  logic [7:0] fa [14] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                          8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'h08, 8'h00};
  logic [7:0] fv [18] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                          8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                          8'h81, 8'h00, 8'h60, 8'h05, 8'h86, 8'hDD};

  int n_chk, n_err;
  int nd [3];
  int ne [3];
  int both_hi;
  int s_d, s_e, s_n;
  logic pvs [3];

  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (hd[j]) nd[j]++;
      if (he[j]) ne[j]++;
      if (hd[j] && he[j]) both_hi++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic s, input logic a, input logic [7:0] d);
    @(negedge clk);
    bus1.rx_data = d; bus1.rx_valid = v; bus1.rx_sof = s; bus1.rx_abort = a;
    #1;
    pvs[V] = pv[V];
    pvs[N] = pv[N];
    @(posedge clk); #1;
    bus1.rx_valid = 1'b0; bus1.rx_sof = 1'b0; bus1.rx_abort = 1'b0;
  endtask

  task automatic drive2(input logic s, input logic [15:0] d);
    @(negedge clk);
    bus2.rx_data = d; bus2.rx_valid = 1'b1; bus2.rx_sof = s; bus2.rx_abort = 1'b0;
    #1;
    pvs[W] = pv[W];
    @(posedge clk); #1;
    bus2.rx_valid = 1'b0; bus2.rx_sof = 1'b0;
  endtask

  initial begin
    bus1.rx_data = '0; bus1.rx_valid = 1'b0; bus1.rx_sof = 1'b0; bus1.rx_abort = 1'b0;
    bus2.rx_data = '0; bus2.rx_valid = 1'b0; bus2.rx_sof = 1'b0; bus2.rx_abort = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_dst%0d", j), dst[j], 0);
      check($sformatf("rst_src%0d", j), src[j], 0);
      check($sformatf("rst_misc%0d", j),
            {ety[j], tci[j], len[j], vp[j], hv[j], hd[j], he[j], pv[j]}, 0);
    end
    rst_n = 1'b1;

    // untagged frame, then four payload beats
    s_d = nd[V];
    for (int i = 0; i < 13; i++) begin
      drive1(1'b1, i == 0, 1'b0, fa[i]);
      if (i == 3) check("hdr_pv", pvs[V], 0);
    end
    check("a_pre_valid", hv[V], 0);
    drive1(1'b1, 1'b0, 1'b0, fa[13]);
    check("a_done", hd[V], 1);
    check("a_valid", hv[V], 1);
    check("a_dst", dst[V], 48'h001122334455);
    check("a_src", src[V], 48'h66778899AABB);
    check("a_type", ety[V], 16'h0800);
    check("a_len", len[V], 14);
    check("a_vp", vp[V], 0);
    check("a_n_type", ety[N], 16'h0800);
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 1'b0, 1'b0, 8'hE0 + 8'(i));
      check("a_pv", pvs[V], 1);
    end
    check("a_ndone", nd[V] - s_d, 1);

    // tagged frame started directly from DONE
    s_d = nd[V]; s_e = ne[V]; s_n = nd[N];
    for (int i = 0; i < 18; i++) begin
      drive1(1'b1, i == 0, 1'b0, fv[i]);
      if (i == 13) begin
        check("v_n_done", hd[N], 1);
        check("v_n_type", ety[N], 16'h8100);
        check("v_n_len", len[N], 14);
        check("v_n_vp", vp[N], 0);
        check("v_mid_valid", hv[V], 0);
        check("v_mid_vp", vp[V], 1);
      end
      if (i == 15) check("v_n_pv", pvs[N], 1);
    end
    check("v_done", hd[V], 1);
    check("v_vp", vp[V], 1);
    check("v_tci", tci[V], 16'h6005);
    check("v_type", ety[V], 16'h86DD);
    check("v_len", len[V], 18);
    check("v_dst", dst[V], 48'h102030405060);
    check("v_src", src[V], 48'h010203040506);
    check("v_n_tci", tci[N], 0);
    drive1(1'b0, 1'b0, 1'b0, 8'h00);
    check("v_ndone", nd[V] - s_d, 1);
    check("v_n_ndone", nd[N] - s_n, 1);
    check("v_nerr", ne[V] - s_e, 0);

    // two-byte lanes with 3-cycle gaps
    s_d = nd[W];
    for (int i = 0; i < 7; i++) begin
      drive2(i == 0, {fa[2*i], fa[2*i+1]});
      if (i == 5) begin
        check("w_pre_valid", hv[W], 0);
        check("w_pre_done", nd[W] - s_d, 0);
      end
      if (i < 6) repeat (3) @(posedge clk);
    end
    check("w_done", hd[W], 1);
    check("w_dst", dst[W], 48'h001122334455);
    check("w_src", src[W], 48'h66778899AABB);
    check("w_type", ety[W], 16'h0800);
    check("w_len", len[W], 14);

    // truncation: 9 bytes of one frame, then a full frame
    s_d = nd[V]; s_e = ne[V];
    for (int i = 0; i < 9; i++) drive1(1'b1, i == 0, 1'b0, fv[i]);
    drive1(1'b1, 1'b1, 1'b0, fa[0]);
    check("t_err", he[V], 1);
    check("t_done", hd[V], 0);
    check("t_clr_dst", dst[V], 0);
    check("t_clr_src", src[V], 0);
    for (int i = 1; i < 14; i++) drive1(1'b1, 1'b0, 1'b0, fa[i]);
    check("t_b_done", hd[V], 1);
    check("t_b_dst", dst[V], 48'h001122334455);
    check("t_b_src", src[V], 48'h66778899AABB);
    check("t_b_type", ety[V], 16'h0800);
    drive1(1'b0, 1'b0, 1'b0, 8'h00);
    check("t_ndone", nd[V] - s_d, 1);
    check("t_nerr", ne[V] - s_e, 1);

    // abort at byte 5, stray beat in IDLE, abort on final beat, abort in DONE
    s_d = nd[V]; s_e = ne[V];
    for (int i = 0; i < 5; i++) drive1(1'b1, i == 0, 1'b0, fv[i]);
    drive1(1'b1, 1'b0, 1'b1, fv[5]);
    check("ab_err", he[V], 1);
    check("ab_valid", hv[V], 0);
    check("ab_dst", dst[V], 48'h102030405000);
    drive1(1'b1, 1'b0, 1'b0, 8'hFF);
    check("ab_idle_dst", dst[V], 48'h102030405000);
    check("ab_idle_pv", pvs[V], 0);
    check("ab_idle_err", he[V], 0);
    for (int i = 0; i < 13; i++) drive1(1'b1, i == 0, 1'b0, fa[i]);
    drive1(1'b1, 1'b0, 1'b1, fa[13]);
    check("abl_done", hd[V], 0);
    check("abl_err", he[V], 1);
    for (int i = 0; i < 14; i++) drive1(1'b1, i == 0, 1'b0, fa[i]);
    check("abd_pre_valid", hv[V], 1);
    drive1(1'b0, 1'b0, 1'b1, 8'h00);
    check("abd_valid", hv[V], 0);
    check("abd_err", he[V], 0);
    drive1(1'b0, 1'b0, 1'b0, 8'h00);
    check("ab_ndone", nd[V] - s_d, 1);
    check("ab_nerr", ne[V] - s_e, 2);

    // asynchronous reset while in VLAN
    for (int i = 0; i < 15; i++) drive1(1'b1, i == 0, 1'b0, fv[i]);
    check("r_mid_vp", vp[V], 1);
    drive1(1'b0, 1'b0, 1'b0, 8'h00);
    s_d = nd[V]; s_e = ne[V];
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("r_dst", dst[V], 0);
    check("r_src", src[V], 0);
    check("r_misc", {ety[V], tci[V], len[V], vp[V], hv[V], hd[V], he[V], pv[V]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("r_after_valid", hv[V], 0);
    check("r_ndone", nd[V] - s_d, 0);
    check("r_nerr", ne[V] - s_e, 0);

    check("no_overlap", both_hi, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
